pulse_transmitter_multichannel: RTL
===================================

Name: pulse_transmitter_multichannel

Overview:
- Parametrised multi-channel successor to the single-channel TinyQV pulse transmitter peripheral.
- Up to 4 independent channels replay 2-bit symbols from one shared symbol memory.
- Each channel has its own start/end window, loop count, idle level, inversion and interrupt enable.
- Sits on the standard TinyQV user-peripheral bus. Channel outputs drive uo_out[7:4].

Parameters:
NUM_CH, 2, number of channels, 1..4
MEM_WORDS, 8, 32-bit symbol words, power of 2, 2..8 (16 symbols/word)
DUR_WIDTH, 8, width of each duration table entry, 1..8

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ui_in  in  8  unused
address  in  6  register byte address
data_in  in  32  write data
data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit
data_read_n  in  2  read strobe, ignored (reads are combinational)
data_out  out  32  read data
data_ready  out  1  constant 1
uo_out  out  8  [4+ch] = channel output; all other bits 0
user_interrupt  out  1  |(done & irq_en)

Behaviour:
- Writes: 0x00 accepts 8-bit or 32-bit writes. All other registers accept 32-bit writes only; other sizes are ignored.
- 0x00 CTRL write:
  - [3:0] W1C done flags.
  - [11:8] start channel.
  - [19:16] stop channel.
  - Stop wins over start. Start of a running channel is ignored.
  - Only 32-bit writes affect [19:8]; an 8-bit write touches only [3:0].
- 0x04 DUR: four DUR_WIDTH-bit entries, symbol s at [8s+DUR_WIDTH-1:8s].
- 0x08 CFG: [3:0] prescaler P; [7:4] idle level; [11:8] invert; [15:12] irq_en. Bits are per channel; bits at or above NUM_CH are ignored.
- 0x10+4ch CHn: [6:0] start idx; [14:8] end idx; [23:16] loop count L; [24] loop forever.
- 0x20+4w: symbol word w. Index bits address[2+log2(MEM_WORDS)-1:2]. Symbol i = word i/16, bits [2(i%16)+1 : 2(i%16)].
- Symbol index width SI = log2(MEM_WORDS*16). Index register bits above SI are ignored, and the pc wraps modulo MEM_WORDS*16.
- Per-channel FSM, IDLE/RUN:
  - IDLE: output = idle^invert. pc = start, loops_left = L.
  - Start accepted at edge E → RUN at E+1. At that edge the channel loads symbol[start]: level = sym[1]; symbol timer = (DUR[sym]+1)·2^P cycles.
  - RUN: output = level^invert. The symbol lasts exactly that many cycles.
  - At expiry, if pc≠end: pc+1 (wrap). The next symbol loads in the same cycle, with no gap.
  - At expiry, if pc==end and (forever or loops_left≠0): pc = start, loops_left−1 (not decremented when forever).
  - At expiry, if pc==end and neither holds: → IDLE and set done[ch].
  - The window plays L+1 times. end<start wraps through the top of memory.
- Prescale counter is per channel and restarts at each symbol load. DUR and P are sampled at symbol load.
- idle, invert and irq_en act combinationally and immediately.
- Symbol or CHn writes during RUN are visible at the next fetch.
- Stop: channel → IDLE next edge. done is not set.
- Flag set and W1C in the same cycle: set wins.
- Channels are fully independent. Simultaneous expiries each set their own done flag.
- Reads:
  - address<0x10 → {16'b0, 4'b0, running[3:0], 4'b0, done[3:0]}.
  - 0x10+4ch → {15'b0, running, loops_left[7:0], 1'b0, pc[6:0]}.
  - Otherwise 0.
- Reset: all registers, memory-independent state, flags and FSMs cleared; channels IDLE. uo_out = 0, user_interrupt = 0. Symbol memory is not reset.
- Reset mid-run returns a channel to IDLE at the next edge.

Test Plan:
- ch0 start=0, end=3, L=0, P=0, DUR={1,2,3,4}, word0=0x000000E4 (symbols 0,1,2,3) → uo_out[4] low 2, low 3, high 4, high 5 clocks. done[0] set at edge E+15; user_interrupt=1 only if irq_en[0].
- Same program with L=2 → sequence repeats 3 times. CH0 read shows loops_left 2→1→0. done set after 42 cycles.
- ch0 and ch1 started in the same write with different windows and P=1 → outputs independent, durations doubled. Both done flags set; W1C 0x1 clears only done[0].
- Start with forever=1, then stop write 0x00010000 mid-symbol → output returns to idle^invert next edge, done stays 0.
- start=126, end=1 (MEM_WORDS=8) → pc sequence 126,127,0,1. Invert toggled mid-run → output flips the same cycle.
- Done set coinciding with W1C of the same bit → flag remains 1. Reset asserted mid-run → uo_out=0, running=0 next edge.

Source files
------------

// File: rtl/pulse_transmitter_multichannel.sv
// Multi-channel pulse transmitter: each channel replays a window of 2-bit symbols
// from a shared symbol memory, with a per-symbol duration table and prescaler.
module pulse_transmitter_multichannel #(
    parameter int NUM_CH    = 2,
    parameter int MEM_WORDS = 8,
    parameter int DUR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [7:0]  uo_out,
    output logic        user_interrupt
);
    localparam int SI = $clog2(MEM_WORDS * 16);
    localparam int WI = $clog2(MEM_WORDS);
    localparam logic [3:0]    CH_MASK = 4'((1 << NUM_CH) - 1);
    localparam logic [SI-1:0] IDX_ONE = SI'(1);

    logic [31:0]          mem [MEM_WORDS];
    logic [DUR_WIDTH-1:0] dur [4];
    logic [SI-1:0]        ch_start [4];
    logic [SI-1:0]        ch_end [4];
    logic [7:0]           ch_loops [4];
    logic [3:0]           ch_forever;
    logic [3:0]           presc, idle_lvl, invert, irq_en, done;
    logic [3:0]           running, ch_out, done_set;
    logic [31:0]          left_all;
    logic [27:0]          pc_all;

    logic       wr32, ctrl_wr;
    logic [3:0] w1c, start_req, stop_req;
    logic       unused_inputs;

    assign wr32      = (data_write_n == 2'b10);
    assign ctrl_wr   = (address == 6'h00) && (wr32 || data_write_n == 2'b00);
    assign w1c       = ctrl_wr ? data_in[3:0] : 4'h0;
    // Start/stop live above the low byte, so only full-word writes can reach them.
    assign start_req = (address == 6'h00 && wr32) ? (data_in[11:8] & CH_MASK) : 4'h0;
    assign stop_req  = (address == 6'h00 && wr32) ? (data_in[19:16] & CH_MASK) : 4'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) begin
                dur[s]      <= '0;
                ch_start[s] <= '0;
                ch_end[s]   <= '0;
                ch_loops[s] <= '0;
            end
            ch_forever <= 4'h0;
            presc      <= 4'h0;
            idle_lvl   <= 4'h0;
            invert     <= 4'h0;
            irq_en     <= 4'h0;
            done       <= 4'h0;
        end else begin
            done <= ((done & ~w1c) | done_set) & CH_MASK;
            if (wr32) begin
                if (address == 6'h04) begin
                    for (int s = 0; s < 4; s++)
                        dur[s] <= data_in[8*s +: DUR_WIDTH];
                end
                if (address == 6'h08) begin
                    presc    <= data_in[3:0];
                    idle_lvl <= data_in[7:4] & CH_MASK;
                    invert   <= data_in[11:8] & CH_MASK;
                    irq_en   <= data_in[15:12] & CH_MASK;
                end
                if (address[5:4] == 2'b01 && CH_MASK[address[3:2]]) begin
                    ch_start[address[3:2]]   <= data_in[SI-1:0];
                    ch_end[address[3:2]]     <= data_in[8 +: SI];
                    ch_loops[address[3:2]]   <= data_in[23:16];
                    ch_forever[address[3:2]] <= data_in[24];
                end
            end
        end
    end

    // Symbol memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr32 && address[5])
            mem[address[2 +: WI]] <= data_in;
    end

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic          run, pend, lvl;
            logic [SI-1:0] pc, nxt_pc;
            logic [7:0]    left;
            logic [23:0]   timer, base, load_cnt;
            logic [31:0]   word;
            logic [1:0]    sym;
            logic          at_end, expire, again;

            // Timer holds remaining cycles minus one; expiry is the cycle it reads zero.
            assign at_end   = (pc == ch_end[c]);
            assign nxt_pc   = (!run || at_end) ? ch_start[c] : pc + IDX_ONE;
            assign word     = mem[nxt_pc[SI-1:4]];
            assign sym      = word[{nxt_pc[3:0], 1'b0} +: 2];
            assign base     = 24'(dur[sym]) + 24'd1;
            assign load_cnt = (base << presc) - 24'd1;
            assign expire   = run && (timer == 24'd0);
            assign again    = !at_end || ch_forever[c] || (left != 8'd0);
            assign done_set[c] = expire && !again && !stop_req[c];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    run   <= 1'b0;
                    pend  <= 1'b0;
                    lvl   <= 1'b0;
                    timer <= 24'd0;
                    pc    <= '0;
                    left  <= 8'd0;
                end else if (stop_req[c]) begin
                    run  <= 1'b0;
                    pend <= 1'b0;
                    pc   <= ch_start[c];
                    left <= ch_loops[c];
                end else if (pend || (expire && again)) begin
                    run   <= 1'b1;
                    pend  <= 1'b0;
                    pc    <= nxt_pc;
                    lvl   <= sym[1];
                    timer <= load_cnt;
                    if (pend)
                        left <= ch_loops[c];
                    else if (at_end && !ch_forever[c])
                        left <= left - 8'd1;
                end else if (expire) begin
                    run  <= 1'b0;
                    pc   <= ch_start[c];
                    left <= ch_loops[c];
                end else if (run) begin
                    timer <= timer - 24'd1;
                end else begin
                    pc   <= ch_start[c];
                    left <= ch_loops[c];
                    pend <= start_req[c];
                end
            end

            assign running[c]          = run;
            assign ch_out[c]           = (run ? lvl : idle_lvl[c]) ^ invert[c];
            assign left_all[8*c +: 8]  = left;
            assign pc_all[7*c +: 7]    = 7'(pc);
        end else begin : g_off
            assign running[c]          = 1'b0;
            assign ch_out[c]           = 1'b0;
            assign done_set[c]         = 1'b0;
            assign left_all[8*c +: 8]  = 8'd0;
            assign pc_all[7*c +: 7]    = 7'd0;
        end
    end

    always_comb begin
        data_out = 32'h0;
        if (address < 6'h10)
            data_out = {20'h0, running, 4'h0, done};
        else if (address[5:4] == 2'b01 && CH_MASK[address[3:2]])
            data_out = {15'h0, running[address[3:2]], left_all[8*address[3:2] +: 8],
                        1'b0, pc_all[7*address[3:2] +: 7]};
    end

    assign data_ready     = 1'b1;
    assign uo_out         = {ch_out, 4'h0};
    assign user_interrupt = |(done & irq_en);
    assign unused_inputs  = &{1'b0, ui_in, data_read_n};

endmodule
